// File: rtl/hamming_pkg.sv
// Shared types and codeword position-mapping helpers for the SECDED codec.
// Functions work on a fixed 64-bit vector; callers pass the real data width.
package hamming_pkg;

    localparam int MAX_CW_W = 64;
    localparam int MAX_P_W  = 6;

    typedef logic [MAX_CW_W-1:0] cw_vec_t;

    typedef enum logic [1:0] {
        ST_CLEAN     = 2'd0,
        ST_CORRECTED = 2'd1,
        ST_UNCORR    = 2'd2
    } codec_status_e;

    function automatic int calc_parity_bits(input int dw);
        int p;
        p = 0;
        for (int k = 1; k <= 7; k++) begin
            if (p == 0 && (1 << k) >= dw + k + 1) begin
                p = k;
            end
        end
        return p;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    // Places data LSB-first into non-power-of-two slots, then fills parity.
    function automatic cw_vec_t data_to_cw(input cw_vec_t data, input int dw);
        cw_vec_t cw;
        int      cww;
        int      j;
        logic    p;
        cww = dw + calc_parity_bits(dw) + 1;
        cw  = '0;
        j   = 0;
        for (int pos = 1; pos < MAX_CW_W; pos++) begin
            if (pos < cww && !is_pow2(pos)) begin
                cw[pos] = data[j];
                j++;
            end
        end
        for (int k = 0; k < MAX_P_W; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < MAX_CW_W; pos++) begin
                if (pos < cww && pos[k]) begin
                    p = p ^ cw[pos];
                end
            end
            if ((1 << k) < cww) begin
                cw[1 << k] = p;
            end
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic cw_vec_t cw_to_data(input cw_vec_t cw, input int dw);
        cw_vec_t data;
        int      cww;
        int      j;
        cww  = dw + calc_parity_bits(dw) + 1;
        data = '0;
        j    = 0;
        for (int pos = 1; pos < MAX_CW_W; pos++) begin
            if (pos < cww && !is_pow2(pos)) begin
                data[j] = cw[pos];
                j++;
            end
        end
        return data;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome (XOR of set-bit indices 1..CW_W-1)
// and overall parity across the full codeword.
module hamming_syndrome #(
    parameter int CW_W = 8,
    parameter int P_W  = $clog2(CW_W)
) (
    input  logic [CW_W-1:0] cw,
    output logic [P_W-1:0]  s,
    output logic            g
);

    always_comb begin
        s = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw[i]) begin
                s = s ^ P_W'(i);
            end
        end
        g = ^cw;
    end

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage valid/ready SECDED codec: capture/encode, then decode/correct
// with saturating corrected/uncorrectable beat counters.
module hamming_secded_codec
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int P_W    = calc_parity_bits(DATA_W),
    localparam int CW_W   = DATA_W + P_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW_W-1:0]   in_cw,
    input  logic [CW_W-1:0]   inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW_W-1:0]   out_cw,
    output logic [1:0]        out_status,
    output logic [P_W-1:0]    out_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_valid;
    logic [CW_W-1:0]   s1_cw;
    logic              s1_adv;
    logic              s2_adv;
    logic              out_fire;

    cw_vec_t           enc_full;
    logic [CW_W-1:0]   enc_cw;
    cw_vec_t           dec_full;
    logic [DATA_W-1:0] dec_data;
    logic [CW_W-1:0]   fixed_cw;
    logic [P_W-1:0]    syn;
    logic              gpar;
    codec_status_e     status;
    logic              unused_fn_bits;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        enc_full = data_to_cw(cw_vec_t'(in_data), DATA_W);
        enc_cw   = enc_full[CW_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw <= (mode ? in_cw : enc_cw) ^ inj_mask;
            end
        end
    end

    hamming_syndrome #(
        .CW_W (CW_W),
        .P_W  (P_W)
    ) u_syn (
        .cw (s1_cw),
        .s  (syn),
        .g  (gpar)
    );

    // Odd overall parity means one flipped bit; s names it (0 = parity bit).
    always_comb begin
        fixed_cw = s1_cw;
        status   = ST_CLEAN;
        if (gpar) begin
            if (syn == '0) begin
                status = ST_CORRECTED;
            end else if (int'(syn) < CW_W) begin
                status   = ST_CORRECTED;
                fixed_cw = s1_cw ^ (CW_W'(1) << syn);
            end else begin
                status = ST_UNCORR;
            end
        end else if (syn != '0) begin
            status = ST_UNCORR;
        end
        dec_full = cw_to_data(cw_vec_t'(fixed_cw), DATA_W);
        dec_data = dec_full[DATA_W-1:0];
    end

    assign unused_fn_bits = ^{enc_full, dec_full};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_cw       <= '0;
            out_data     <= '0;
            out_status   <= 2'd0;
            out_syndrome <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_cw       <= s1_cw;
                out_data     <= dec_data;
                out_status   <= status;
                out_syndrome <= syn;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_fire) begin
            if (out_status == ST_CORRECTED && corr_cnt != CNT_MAX) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (out_status == ST_UNCORR && uncorr_cnt != CNT_MAX) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule
